pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised pipeline stage register for the pipelined MIPS core. It replaces the plain
//   fixed-width stage register between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush and bubble
//   insertion, so hazard and branch logic can stall or squash any stage.
//   Full throughput of 1 transfer/cycle; in_ready is registered to break combinational paths.
// PARAMETERS
//   WIDTH         64        payload width in bits (e.g. {PC+4, instruction} = 64)
//   BUBBLE_VALUE  {WIDTH{0}} value driven on out_data when out_valid=0 (NOP/bubble encoding)
// PORTS
//   clk        in   1      rising-edge clock
//   resetN     in   1      asynchronous, active-low reset
//   flush      in   1      synchronous squash of all held entries
//   in_valid   in   1      upstream has data on in_data
//   in_ready   out  1      stage can accept data (registered)
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      out_data holds a valid entry
//   out_ready  in   1      downstream accepts out_data this cycle
//   out_data   out  WIDTH  head payload; BUBBLE_VALUE when out_valid=0
//   occupancy  out  2      number of held entries, 0..2
// BEHAVIOUR
//   - One clock domain; reset is asynchronous, active-low.
//   - Reset (resetN=0): state EMPTY, out_valid=0, out_data=BUBBLE_VALUE,
//     in_ready=1, occupancy=0, skid entry=BUBBLE_VALUE. Outputs change immediately, not on clk.
//   - Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
//   - Storage: main register (drives out_data) + skid register. FSM states EMPTY/FULL/SKID.
//   - EMPTY: in_xfer -> FULL, main<=in_data. No in_xfer -> stay EMPTY.
//   - FULL: in_xfer&out_xfer -> FULL, main<=in_data. in_xfer only -> SKID, skid<=in_data.
//     out_xfer only -> EMPTY, main<=BUBBLE_VALUE. Neither -> hold.
//   - SKID: in_ready=0, so no in_xfer. out_xfer -> FULL, main<=skid, skid<=BUBBLE_VALUE.
//     No out_xfer -> hold both entries.
//   - in_ready next = (next state != SKID); it is a flop, not a function of out_ready.
//   - Latency: data accepted in cycle N appears on out_data in N+1 if no older entry is held.
//   - Ordering: strict FIFO, no loss, no duplication under any in_valid/out_ready pattern.
//   - occupancy = 0/1/2 in EMPTY/FULL/SKID; registered, matches the state.
//   - flush=1 has priority over all transfers: next state EMPTY, main and skid<=BUBBLE_VALUE,
//     in_ready=1. An in_xfer in the flush cycle is discarded. An out_xfer in the flush cycle
//     is still consumed downstream (it was presented). flush has no effect while resetN=0.
//   - in_valid may drop without a transfer; in_data is sampled only on in_xfer.
//   - X on in_data while in_valid=0 must not propagate to out_data.
// TESTING
//   1. Reset mid-stream: SKID state, pull resetN=0 between edges -> out_valid=0,
//      out_data=BUBBLE_VALUE, in_ready=1, occupancy=0 before the next clk edge.
//   2. Streaming: out_ready=1, push 0x1..0x5 back-to-back -> out_data 0x1..0x5 one cycle
//      later each, in_ready held 1, occupancy=1 throughout.
//   3. Backpressure: out_ready=0, push A,B,C -> A in main, B in skid, in_ready=0 after B,
//      C held by upstream; raise out_ready -> A,B,C delivered in order, no loss/duplicate.
//   4. Flush in SKID with in_valid=1 -> next cycle out_valid=0, occupancy=0,
//      out_data=BUBBLE_VALUE, in_ready=1; the in_data of the flush cycle never appears.
//   5. FULL with in_xfer and out_xfer in the same cycle -> occupancy stays 1 and
//      out_data = new in_data next cycle.
//   6. WIDTH=32, BUBBLE_VALUE=32'h0000_0020 -> idle out_data=32'h0000_0020; random
//      in_valid/out_ready for 10k cycles against a scoreboard -> zero mismatches.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// It supports synchronous flush and bubble insertion, and its in_ready output is registered.
module pipe_stage_reg #(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // The state encoding is chosen so that it equals the number of held entries.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]       state_p1, state_nxt;
  logic [WIDTH-1:0] main_p1, main_nxt;
  logic [WIDTH-1:0] skid_p1, skid_nxt;
  logic             rdy_p1;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid & rdy_p1;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_nxt = state_p1;
    main_nxt  = main_p1;
    skid_nxt  = skid_p1;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_nxt  = BUBBLE_VALUE;
      skid_nxt  = BUBBLE_VALUE;
    end else begin
      case (state_p1)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_nxt = ST_FULL;
            main_nxt  = in_data;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_nxt = in_data;
          end else if (in_xfer) begin
            state_nxt = ST_SKID;
            skid_nxt  = in_data;
          end else if (out_xfer) begin
            state_nxt = ST_EMPTY;
            main_nxt  = BUBBLE_VALUE;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            state_nxt = ST_FULL;
            main_nxt  = skid_p1;
            skid_nxt  = BUBBLE_VALUE;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
          main_nxt  = BUBBLE_VALUE;
          skid_nxt  = BUBBLE_VALUE;
        end
      endcase
    end
  end

  // Stage boundary: both held entries and the registered ready flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_p1 <= ST_EMPTY;
      main_p1  <= BUBBLE_VALUE;
      skid_p1  <= BUBBLE_VALUE;
      rdy_p1   <= 1'b1;
    end else begin
      state_p1 <= state_nxt;
      main_p1  <= main_nxt;
      skid_p1  <= skid_nxt;
      rdy_p1   <= (state_nxt != ST_SKID);
    end
  end

  // The main register is kept at BUBBLE_VALUE whenever the stage is empty.
  assign out_valid = (state_p1 != ST_EMPTY);
  assign out_data  = main_p1;
  assign in_ready  = rdy_p1;
  assign occupancy = state_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg with WIDTH=32 and a non-zero bubble encoding.
// The reference model is a bounded FIFO queue; every output is checked after each clock edge.
module tb_pipe_stage_reg;
  localparam int          W      = 32;
  localparam logic [31:0] BUBBLE = 32'h0000_0020;

  logic          clk = 1'b0;
  logic          resetN = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] dq[$];

  pipe_stage_reg #(.WIDTH(W), .BUBBLE_VALUE(BUBBLE)) dut (
    .clk(clk), .resetN(resetN), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_data();
    return (mq.size() > 0) ? mq[0] : BUBBLE;
  endfunction

  function automatic logic [1:0] exp_occ();
    return 2'(mq.size());
  endfunction

  // Applies one cycle of inputs, advances the FIFO model and leaves the bench 1 time unit after the edge.
  task automatic drive_cycle(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    bit ixf, oxf;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    ixf = iv && (mq.size() < 2);
    oxf = ordy && (mq.size() > 0);
    if (oxf) dq.push_back(mq[0]);
    if (fl) mq.delete();
    else begin
      if (oxf) void'(mq.pop_front());
      if (ixf) mq.push_back(id);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    #1 resetN = 1'b0;
    #1;
    mq.delete();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_initial: valid=%0b data=%h ready=%0b occ=%0d, want 0 %h 1 0",
               out_valid, out_data, in_ready, occupancy, BUBBLE);
    end
    @(posedge clk);
    #1 resetN = 1'b1;
    drive_cycle(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL reset_fill_skid: occ=%0d ready=%0b data=%h, want 2 0 aaaa0001",
               occupancy, in_ready, out_data);
    end
    in_valid = 1'b0;
    #2 resetN = 1'b0;
    #1;
    mq.delete();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: valid=%0b data=%h ready=%0b occ=%0d, want 0 %h 1 0",
               out_valid, out_data, in_ready, occupancy, BUBBLE);
    end
    #1 resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 5; i++) begin
      drive_cycle(1'b1, W'(i), 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i) || in_ready !== 1'b1 || occupancy !== 2'd1) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%0b data=%h ready=%0b occ=%0d, want 1 %h 1 1",
                 i, out_valid, out_data, in_ready, occupancy, W'(i));
      end
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%0b data=%h occ=%0d, want 0 %h 0",
               out_valid, out_data, occupancy, BUBBLE);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, c;
    bit c_sent;
    a = 32'h1111_000A; b = 32'h2222_000B; c = 32'h3333_000C;
    dq.delete();
    drive_cycle(1'b1, a, 1'b0, 1'b0);
    drive_cycle(1'b1, b, 1'b0, 1'b0);
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a) begin
      n_fail++;
      $display("FAIL bp_after_b: occ=%0d ready=%0b data=%h, want 2 0 %h", occupancy, in_ready, out_data, a);
    end
    drive_cycle(1'b1, c, 1'b0, 1'b0);
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a) begin
      n_fail++;
      $display("FAIL bp_hold_c: occ=%0d ready=%0b data=%h, want 2 0 %h", occupancy, in_ready, out_data, a);
    end
    c_sent = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bit send;
      send = !c_sent;
      if (send && in_ready) c_sent = 1'b1;
      drive_cycle(send, c, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== (mq.size() > 0) || out_data !== exp_data() || in_ready !== (mq.size() < 2) ||
          occupancy !== exp_occ()) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: valid=%0b data=%h ready=%0b occ=%0d, want %0b %h %0b %0d", k,
                 out_valid, out_data, in_ready, occupancy, mq.size() > 0, exp_data(), mq.size() < 2, exp_occ());
      end
    end
    n_checks++;
    if (dq.size() != 3 || dq[0] !== a || dq[1] !== b || dq[2] !== c) begin
      n_fail++;
      $display("FAIL bp_order: delivered %0d items, first=%h, want 3 items %h %h %h",
               dq.size(), (dq.size() > 0) ? dq[0] : 32'h0, a, b, c);
    end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 32'h5555_0001, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h5555_0002, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== BUBBLE || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_skid: valid=%0b data=%h ready=%0b occ=%0d, want 0 %h 1 0",
               out_valid, out_data, in_ready, occupancy, BUBBLE);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE) begin
      n_fail++;
      $display("FAIL flush_no_leak: valid=%0b data=%h, want 0 %h", out_valid, out_data, BUBBLE);
    end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 32'h7777_0001, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h7777_0002, 1'b1, 1'b0);
    n_checks++;
    if (occupancy !== 2'd1 || out_data !== 32'h7777_0002 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_full: occ=%0d data=%h ready=%0b, want 1 77770002 1", occupancy, out_data, in_ready);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int k = 0; k < 10000; k++) begin
      logic iv, ordy, fl;
      logic [W-1:0] id;
      iv   = 1'($urandom % 2);
      ordy = 1'($urandom % 2);
      fl   = (($urandom % 64) == 0);
      id   = $urandom;
      drive_cycle(iv, id, ordy, fl);
      n_checks++;
      if (out_valid !== (mq.size() > 0) || out_data !== exp_data() || in_ready !== (mq.size() < 2) ||
          occupancy !== exp_occ()) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d: valid=%0b data=%h ready=%0b occ=%0d, want %0b %h %0b %0d", k,
                   out_valid, out_data, in_ready, occupancy, mq.size() > 0, exp_data(), mq.size() < 2, exp_occ());
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
